tmr_sum_scheduler: RTL and testbench

Shares one triple-modular-redundant adder-tree instance (`tmr_adder_tree`, Q6.10, 8 operands) between the two neurons of a TwoNeuron layer. Requests are arbitrated round-robin and the operand vector is registered into the tree. The voted sum is sampled one cycle later and re-evaluated on a no-majority (`invalid`) vote, up to a retry limit. The sum is then returned to the granted neuron with a fault flag, and a saturating error counter is kept for the FT monitor.

---
 rtl/tmr_sched_pkg.sv | 15 +
 rtl/rr_arb2.sv | 20 ++
 rtl/tmr_adder_tree.sv | 48 ++++
 rtl/tmr_sum_scheduler.sv | 164 ++++++++++++++++
 tb/tb_tmr_sum_scheduler.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmr_sched_pkg.sv
// Shared types and Q-format constants for the TMR sum scheduler.
package tmr_sched_pkg;

  localparam int unsigned INTBITS  = 6;
  localparam int unsigned FRACBITS = 10;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StResp
  } sched_state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not granted last time wins.
module rr_arb2
  import tmr_sched_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_idx_t   last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/tmr_adder_tree.sv
// Triple-redundant M-operand wrapping adder with a 2-of-3 voter.
// With no majority, invalid_o is raised and copy 1 is passed through as the fallback.
module tmr_adder_tree #(
  parameter int unsigned M        = 8,
  parameter int unsigned N        = 16,
  parameter int unsigned INTBITS  = 6,
  parameter int unsigned FRACBITS = 10
) (
  input  logic [N*M-1:0] operands_i,
  output logic [N-1:0]   result_o,
  output logic           invalid_o
);

  if (INTBITS + FRACBITS != N) begin : g_fmt_check
    $error("tmr_adder_tree: INTBITS + FRACBITS must equal N");
  end

  // Fixed-point sums need no alignment; overflow wraps modulo 2^N.
  function automatic logic [N-1:0] add_all(input logic [N*M-1:0] ops);
    logic [N-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < M; i++) begin
      acc = acc + ops[i*N +: N];
    end
    return acc;
  endfunction

  logic [N-1:0] sum0;
  logic [N-1:0] sum1;
  logic [N-1:0] sum2;

  assign sum0 = add_all(operands_i);
  assign sum1 = add_all(operands_i);
  assign sum2 = add_all(operands_i);

  always_comb begin
    invalid_o = 1'b0;
    result_o  = sum1;
    if (sum0 == sum1 || sum0 == sum2) begin
      result_o = sum0;
    end else if (sum1 == sum2) begin
      result_o = sum1;
    end else begin
      invalid_o = 1'b1;
    end
  end

endmodule

// File: rtl/tmr_sum_scheduler.sv
// Shares one TMR adder tree between two neurons: round-robin accept, evaluate with
// retry on a no-majority vote, then a one-cycle response pulse to the granted neuron.
module tmr_sum_scheduler
  import tmr_sched_pkg::*;
#(
  parameter int unsigned M         = 8,
  parameter int unsigned N         = 16,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [N*M-1:0]   req0_operand,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [N*M-1:0]   req1_operand,
  output logic             req1_ready,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [N-1:0]     resp_result,
  output logic             resp_fault,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int unsigned       RetryW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [CNT_W-1:0]  ErrMax   = '1;

  sched_state_e      state_q, state_d;
  req_idx_t          last_grant_q, last_grant_d;
  req_idx_t          gnt_q, gnt_d;
  logic [N*M-1:0]    op_q, op_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [N-1:0]      res_q, res_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  err_q, err_d;

  logic [1:0]   grant;
  logic         accept;
  logic [N-1:0] tree_result;
  logic         tree_invalid;

  rr_arb2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  tmr_adder_tree #(
    .M        (M),
    .N        (N),
    .INTBITS  (INTBITS),
    .FRACBITS (FRACBITS)
  ) u_tree (
    .operands_i (op_q),
    .result_o   (tree_result),
    .invalid_o  (tree_invalid)
  );

  assign accept = (state_q == StIdle) && (grant != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StEval;
      StEval: if (!tree_invalid || !(retry_q < RetryMax)) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_q         <= '0;
      retry_q      <= '0;
      res_q        <= '0;
      fault_q      <= 1'b0;
      err_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op_q         <= op_d;
      retry_q      <= retry_d;
      res_q        <= res_d;
      fault_q      <= fault_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    op_d         = op_q;
    retry_d      = retry_q;
    res_d        = res_q;
    fault_d      = fault_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = grant[1] ? req1_operand : req0_operand;
          gnt_d   = req_idx_t'(grant[1]);
          retry_d = '0;
        end
      end
      StEval: begin
        if (!tree_invalid) begin
          res_d   = tree_result;
          fault_d = 1'b0;
        end else if (retry_q < RetryMax) begin
          retry_d = retry_q + 1'b1;
        end else begin
          // Retries exhausted: tree passes copy 1 through unvoted.
          res_d   = tree_result;
          fault_d = 1'b1;
        end
        if (tree_invalid && err_q != ErrMax) begin
          err_d = err_q + 1'b1;
        end
      end
      StResp: last_grant_d = gnt_q;
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
      end
      StResp: begin
        resp0_valid = (gnt_q == 1'b0);
        resp1_valid = (gnt_q == 1'b1);
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign resp_result = res_q;
  assign resp_fault  = fault_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_tmr_sum_scheduler.sv
// Self-checking bench for tmr_sum_scheduler: directed scenarios plus randomized
// requests checked against a plain-arithmetic sum model.
`timescale 1ns/1ps
module tb_tmr_sum_scheduler;

  localparam int M  = 8;
  localparam int N  = 16;
  localparam int OW = N * M;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic          req1_valid = 1'b0;
  logic [OW-1:0] req0_operand = '0;
  logic [OW-1:0] req1_operand = '0;
  logic          req0_ready, req1_ready, resp0_valid, resp1_valid, resp_fault, busy;
  logic [N-1:0]  resp_result;
  logic [7:0]    err_count;

  int checks  = 0;
  int errors  = 0;
  int exp_err = 0;
  logic [N-1:0] f0_val, f1_val, f2_val;

  always #5 clk = ~clk;

  tmr_sum_scheduler #(
    .M         (M),
    .N         (N),
    .MAX_RETRY (2),
    .CNT_W     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_operand (req0_operand),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_operand (req1_operand),
    .req1_ready   (req1_ready),
    .resp0_valid  (resp0_valid),
    .resp1_valid  (resp1_valid),
    .resp_result  (resp_result),
    .resp_fault   (resp_fault),
    .err_count    (err_count),
    .busy         (busy)
  );

  function automatic logic [OW-1:0] rand_ops();
    logic [OW-1:0] v;
    for (int i = 0; i < M; i++) v[i*N +: N] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [N-1:0] model_sum(input logic [OW-1:0] v);
    int unsigned acc;
    acc = 0;
    for (int i = 0; i < M; i++) acc = (acc + v[i*N +: N]) % 65536;
    return 16'(acc);
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  // Mode 0: clean; 1: one copy wrong; 2: three distinct for first EVAL only;
  // 3: three distinct for the whole request. Latencies count from the handshake cycle.
  task automatic do_request(input int nid, input logic [OW-1:0] ops, input int mode,
                            output int acc_wait, output int lat, output int rnid,
                            output logic [N-1:0] res, output logic flt);
    logic [N-1:0] s;
    bit got;
    s = model_sum(ops);
    acc_wait = -1; lat = -1; rnid = -1; res = 'x; flt = 1'bx;
    @(negedge clk);
    if (nid == 0) begin req0_valid = 1'b1; req0_operand = ops; end
    else begin req1_valid = 1'b1; req1_operand = ops; end
    #1;
    got = 0;
    for (int w = 0; w < 8; w++) begin
      if (w > 0) begin @(negedge clk); #1; end
      if ((nid == 0) ? req0_ready : req1_ready) begin acc_wait = w; got = 1; break; end
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!got) return;
    f0_val = s ^ 16'h0001;
    f1_val = s ^ 16'h0004;
    f2_val = s ^ 16'h0002;
    if (mode == 1) force dut.u_tree.sum2 = f2_val;
    if (mode >= 2) begin
      force dut.u_tree.sum0 = f0_val;
      force dut.u_tree.sum2 = f2_val;
    end
    if (mode == 3) force dut.u_tree.sum1 = f1_val;
    for (int l = 1; l <= 8; l++) begin
      if (l > 1) @(negedge clk);
      if (mode == 2 && l == 2) begin
        release dut.u_tree.sum0;
        release dut.u_tree.sum2;
      end
      #1;
      if (resp0_valid || resp1_valid) begin
        lat = l; rnid = resp1_valid ? 1 : 0; res = resp_result; flt = resp_fault;
        break;
      end
    end
    if (mode == 1 || mode == 3) release dut.u_tree.sum2;
    if (mode == 3) begin
      release dut.u_tree.sum0;
      release dut.u_tree.sum1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_handshakes got %b want 0000",
                         {req0_ready, req1_ready, resp0_valid, resp1_valid}); end
    checks++; if (resp_result !== 16'h0000 || resp_fault !== 1'b0) begin
      errors++; $display("FAIL reset_resp got %h/%b want 0000/0", resp_result, resp_fault); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int aw, lat, rn; logic [N-1:0] res; logic flt; logic [OW-1:0] ops;
    for (int i = 0; i < M; i++) ops[i*N +: N] = 16'h0400;
    do_request(0, ops, 0, aw, lat, rn, res, flt);
    checks++; if (aw !== 0) begin errors++; $display("FAIL single_ready_wait got %0d want 0", aw); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", lat); end
    checks++; if (rn !== 0) begin errors++; $display("FAIL single_neuron got %0d want 0", rn); end
    checks++; if (res !== 16'h2000) begin errors++; $display("FAIL single_result got %h want 2000", res); end
    checks++; if (flt !== 1'b0) begin errors++; $display("FAIL single_fault got %b want 0", flt); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL single_err got %0d want 0", err_count); end
    @(negedge clk); #1;
    checks++; if (resp0_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_pulse got valid=%b busy=%b want 0/0", resp0_valid, busy); end
    checks++; if (resp_result !== 16'h2000) begin
      errors++; $display("FAIL single_hold got %h want 2000", resp_result); end
  endtask

  task automatic test_contention();
    int g_cyc[$], g_who[$], r_cyc[$], r_who[$];
    logic [N-1:0] g_sum[$], r_res[$];
    bit new0, new1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_err = 0;
    new0 = 1; new1 = 1;
    for (int c = 0; c < 20 && r_cyc.size() < 4; c++) begin
      @(negedge clk);
      if (new0) req0_operand = rand_ops();
      if (new1) req1_operand = rand_ops();
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      new0 = req0_ready; new1 = req1_ready;
      if (req0_ready) begin g_cyc.push_back(c); g_who.push_back(0); g_sum.push_back(model_sum(req0_operand)); end
      if (req1_ready) begin g_cyc.push_back(c); g_who.push_back(1); g_sum.push_back(model_sum(req1_operand)); end
      if (resp0_valid) begin r_cyc.push_back(c); r_who.push_back(0); r_res.push_back(resp_result); end
      if (resp1_valid) begin r_cyc.push_back(c); r_who.push_back(1); r_res.push_back(resp_result); end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (r_cyc.size() < 4 || g_cyc.size() < 4) begin
      errors++; $display("FAIL contention_count got %0d grants %0d resps want 4", g_cyc.size(), r_cyc.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < g_cyc.size() && k < r_cyc.size()) begin
        checks++; if (g_who[k] !== k % 2 || g_cyc[k] !== 3 * k) begin
          errors++; $display("FAIL contention_grant%0d got n%0d@%0d want n%0d@%0d",
                             k, g_who[k], g_cyc[k], k % 2, 3 * k); end
        checks++; if (r_who[k] !== g_who[k] || r_cyc[k] !== g_cyc[k] + 2) begin
          errors++; $display("FAIL contention_resp%0d got n%0d@%0d want n%0d@%0d",
                             k, r_who[k], r_cyc[k], g_who[k], g_cyc[k] + 2); end
        checks++; if (r_res[k] !== g_sum[k]) begin
          errors++; $display("FAIL contention_result%0d got %h want %h", k, r_res[k], g_sum[k]); end
      end
    end
  endtask

  task automatic test_transient();
    int aw, lat, rn; logic [N-1:0] res; logic flt; logic [OW-1:0] ops;
    ops = rand_ops();
    do_request(0, ops, 1, aw, lat, rn, res, flt);
    checks++; if (res !== model_sum(ops) || lat !== 2) begin
      errors++; $display("FAIL onecopy got %h@%0d want %h@2", res, lat, model_sum(ops)); end
    checks++; if (err_count !== 8'(exp_err) || flt !== 1'b0) begin
      errors++; $display("FAIL onecopy_err got %0d/%b want %0d/0", err_count, flt, exp_err); end
    ops = rand_ops();
    do_request(1, ops, 2, aw, lat, rn, res, flt);
    exp_err = sat_add(exp_err, 1);
    checks++; if (lat !== 3 || rn !== 1) begin
      errors++; $display("FAIL retry_latency got n%0d@%0d want n1@3", rn, lat); end
    checks++; if (res !== model_sum(ops) || flt !== 1'b0) begin
      errors++; $display("FAIL retry_result got %h/%b want %h/0", res, flt, model_sum(ops)); end
    checks++; if (err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL retry_err got %0d want %0d", err_count, exp_err); end
  endtask

  task automatic test_persistent();
    int aw, lat, rn; logic [N-1:0] res; logic flt; logic [OW-1:0] ops;
    ops = rand_ops();
    do_request(0, ops, 3, aw, lat, rn, res, flt);
    exp_err = sat_add(exp_err, 3);
    checks++; if (lat !== 4 || flt !== 1'b1) begin
      errors++; $display("FAIL persist_resp got %0d/%b want 4/1", lat, flt); end
    checks++; if (res !== (model_sum(ops) ^ 16'h0004)) begin
      errors++; $display("FAIL persist_copy1 got %h want %h", res, model_sum(ops) ^ 16'h0004); end
    checks++; if (err_count !== 8'(exp_err)) begin
      errors++; $display("FAIL persist_err got %0d want %0d", err_count, exp_err); end
  endtask

  task automatic test_saturation();
    int aw, lat, rn; logic [N-1:0] res; logic flt;
    for (int i = 0; i < 85; i++) begin
      do_request(i % 2, rand_ops(), 3, aw, lat, rn, res, flt);
      exp_err = sat_add(exp_err, 3);
      checks++; if (err_count !== 8'(exp_err)) begin
        errors++; $display("FAIL sat_err%0d got %0d want %0d", i, err_count, exp_err); end
    end
  endtask

  task automatic test_reset_mid_eval();
    int pulses;
    @(negedge clk);
    req1_valid = 1'b1; req1_operand = rand_ops();
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rstmid_accept got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_eval got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      #1; if (resp0_valid || resp1_valid) pulses++;
      @(negedge clk);
    end
    #1;
    checks++; if (pulses !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop got pulses=%0d busy=%b want 0/0", pulses, busy); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rstmid_err got %0d want 0", err_count); end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_operand = rand_ops(); req1_operand = rand_ops();
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL rstmid_winner got %b want 01", {req1_ready, req0_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int aw, lat, rn, nid; logic [N-1:0] res; logic flt; logic [OW-1:0] ops;
    for (int i = 0; i < 16; i++) begin
      nid = int'($urandom_range(0, 1));
      ops = (i == 0) ? '1 : rand_ops();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_request(nid, ops, 0, aw, lat, rn, res, flt);
      checks++; if (aw !== 0 || lat !== 2 || rn !== nid) begin
        errors++; $display("FAIL rand%0d_timing got w%0d l%0d n%0d want w0 l2 n%0d", i, aw, lat, rn, nid); end
      checks++; if (res !== model_sum(ops) || flt !== 1'b0) begin
        errors++; $display("FAIL rand%0d_result got %h/%b want %h/0", i, res, flt, model_sum(ops)); end
      checks++; if (err_count !== 8'(exp_err)) begin
        errors++; $display("FAIL rand%0d_err got %0d want %0d", i, err_count, exp_err); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_transient();
    test_persistent();
    test_saturation();
    test_reset_mid_eval();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
